// File: rtl/psm_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : psm_tx_sched
//  Description : Per-port transmit scheduler. Round-robin, frame-granular
//                sharing of one PSM transmitter between NREQ byte sources,
//                with inter-frame gap, inactivity timeout and link-down abort.
//  Revision    : 1.0  initial release
// ============================================================================
module psm_tx_sched #(
    parameter int NREQ    = 4,
    parameter int PORT    = 0,
    parameter int IFG_CYC = 24,
    parameter int TO_CYC  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      grant,
    input  logic [NREQ-1:0]      in_valid,
    input  logic [16*NREQ-1:0]   in_byte,
    input  logic [8*NREQ-1:0]    in_data,
    input  logic                 port_link,
    output logic                 tx_valid,
    output logic [1:0]           tx_port,
    output logic [15:0]          tx_byte,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [15:0]          abort_cnt,
    output logic [15:0]          bad_cnt
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_TW = $clog2(TO_CYC + 1);
    localparam int c_FW = $clog2(IFG_CYC + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_IFG   = 2'd2;

    localparam logic [15:0] c_END_GOOD = 16'hFFFF;
    localparam logic [15:0] c_END_BAD  = 16'hFFFE;

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_grant;
    logic [c_IW-1:0] r_gidx;
    logic [c_IW-1:0] r_rr;
    logic [c_TW-1:0] r_to_cnt;
    logic [c_FW-1:0] r_ifg_cnt;
    logic            r_tx_valid;
    logic [15:0]     r_tx_byte;
    logic [7:0]      r_tx_data;
    logic [15:0]     r_abort_cnt;
    logic [15:0]     r_bad_cnt;

    logic            w_any;
    logic [c_IW-1:0] w_sel;
    logic [c_IW:0]   w_cand;
    logic [NREQ-1:0] w_sel_oh;
    logic [c_IW-1:0] w_rr_next;
    logic            w_g_valid;
    logic [15:0]     w_g_byte;
    logic [7:0]      w_g_data;
    logic            w_marker;
    logic            w_to_hit;
    logic            w_abort;

    // Search starts at the rr pointer and wraps, so the first hit is the fair winner.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, r_rr} + (c_IW+1)'(i);
            if (w_cand >= (c_IW+1)'(NREQ)) begin
                w_cand = w_cand - (c_IW+1)'(NREQ);
            end
            if (!w_any && req[w_cand[c_IW-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_cand[c_IW-1:0];
            end
        end
    end

    assign w_sel_oh  = NREQ'(1) << w_sel;
    assign w_rr_next = (w_sel == c_IW'(NREQ - 1)) ? '0 : w_sel + c_IW'(1);

    assign w_g_valid = in_valid[r_gidx];
    assign w_g_byte  = in_byte[{r_gidx, 4'b0000} +: 16];
    assign w_g_data  = in_data[{r_gidx, 3'b000} +: 8];
    assign w_marker  = (w_g_byte == c_END_GOOD) || (w_g_byte == c_END_BAD);

    // Timeout fires on the TO_CYC-th consecutive silent cycle of the grant.
    assign w_to_hit  = !w_g_valid && (r_to_cnt == c_TW'(TO_CYC - 1));
    assign w_abort   = !port_link || w_to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_rr        <= '0;
            r_to_cnt    <= '0;
            r_ifg_cnt   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_byte   <= '0;
            r_tx_data   <= '0;
            r_abort_cnt <= '0;
            r_bad_cnt   <= '0;
        end else begin
            r_tx_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (port_link && w_any) begin
                        r_grant  <= w_sel_oh;
                        r_gidx   <= w_sel;
                        r_rr     <= w_rr_next;
                        r_to_cnt <= '0;
                        r_state  <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    if (w_abort) begin
                        // Abort has priority over a marker or byte in the same cycle.
                        r_grant   <= '0;
                        r_ifg_cnt <= '0;
                        r_state   <= c_ST_IFG;
                        if (r_abort_cnt != 16'hFFFF) begin
                            r_abort_cnt <= r_abort_cnt + 16'd1;
                        end
                    end else if (w_g_valid) begin
                        r_to_cnt <= '0;
                        if (w_marker) begin
                            r_grant   <= '0;
                            r_ifg_cnt <= '0;
                            r_state   <= c_ST_IFG;
                            if ((w_g_byte == c_END_BAD) && (r_bad_cnt != 16'hFFFF)) begin
                                r_bad_cnt <= r_bad_cnt + 16'd1;
                            end
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_tx_byte  <= w_g_byte;
                            r_tx_data  <= w_g_data;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TW'(1);
                    end
                end
                c_ST_IFG: begin
                    if (r_ifg_cnt == c_FW'(IFG_CYC - 1)) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + c_FW'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign tx_valid  = r_tx_valid;
    assign tx_port   = 2'(PORT);
    assign tx_byte   = r_tx_byte;
    assign tx_data   = r_tx_data;
    assign busy      = (r_state != c_ST_IDLE);
    assign abort_cnt = r_abort_cnt;
    assign bad_cnt   = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_psm_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psm_tx_sched
//  Description : Scoreboard bench for psm_tx_sched; forwarded bytes are
//                queued when driven and popped when tx_valid appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psm_tx_sched;

    localparam int NREQ    = 4;
    localparam int IFG_CYC = 24;
    localparam int TO_CYC  = 256;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     in_valid;
    logic [16*NREQ-1:0]  in_byte;
    logic [8*NREQ-1:0]   in_data;
    logic                port_link;
    logic                tx_valid;
    logic [1:0]          tx_port;
    logic [15:0]         tx_byte;
    logic [7:0]          tx_data;
    logic                busy;
    logic [15:0]         abort_cnt;
    logic [15:0]         bad_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] sb[$];

    psm_tx_sched #(
        .NREQ   (NREQ),
        .PORT   (0),
        .IFG_CYC(IFG_CYC),
        .TO_CYC (TO_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_data  (in_data),
        .port_link(port_link),
        .tx_valid (tx_valid),
        .tx_port  (tx_port),
        .tx_byte  (tx_byte),
        .tx_data  (tx_data),
        .busy     (busy),
        .abort_cnt(abort_cnt),
        .bad_cnt  (bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every tx_valid pulse must match the oldest queued byte.
    always @(posedge clk) begin
        logic [23:0] exp;
        #1;
        if (rst_n === 1'b1 && tx_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got byte=%h data=%h, required no tx_valid", tx_byte, tx_data);
            end else begin
                exp = sb.pop_front();
                if ({tx_byte, tx_data} !== exp) begin
                    errors++;
                    $display("FAIL tx_payload: got %h/%h, required %h/%h", tx_byte, tx_data, exp[23:8], exp[7:0]);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        in_valid  = '0;
        in_byte   = '0;
        in_data   = '0;
        port_link = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic drive_byte(input int s, input logic [15:0] idx, input logic [7:0] d, input bit fwd);
        @(negedge clk);
        in_valid[s]         = 1'b1;
        in_byte[s*16 +: 16] = idx;
        in_data[s*8 +: 8]   = d;
        if (fwd) sb.push_back({idx, d});
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({grant, tx_valid, tx_byte, tx_data, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b v=%b byte=%h data=%h busy=%b, required all 0",
                     grant, tx_valid, tx_byte, tx_data, busy);
        end
        checks++;
        if ({abort_cnt, bad_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got abort=%0d bad=%0d, required 0/0", abort_cnt, bad_cnt);
        end
        checks++;
        if (tx_port !== 2'd0) begin
            errors++;
            $display("FAIL tx_port: got %0d, required 0", tx_port);
        end
    endtask

    task automatic test_single_frame();
        int n;
        do_reset();
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_grant: got grant=%b busy=%b, required 0001/1", grant, busy);
        end
        req = '0;
        for (int i = 0; i < 5; i++) drive_byte(0, 16'(i + 1), 8'hA0 + 8'(i), 1'b1);
        drive_byte(0, 16'hFFFF, 8'h00, 1'b0);
        checks++;
        if (grant !== 4'b0000 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_end: got grant=%b tx_valid=%b, required 0000/0", grant, tx_valid);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != IFG_CYC) begin
            errors++;
            $display("FAIL t1_ifg: got %0d busy cycles after end, required %0d", n, IFG_CYC);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL t1_missing: got %0d bytes not sent, required 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        int gap;
        logic [NREQ-1:0] exp_g;
        do_reset();
        @(negedge clk);
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            gap = 0;
            while (grant === 4'b0000 && gap < 200) begin
                gap++;
                @(posedge clk);
                #1;
            end
            exp_g = 4'b0001 << (f % 4);
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL t2_order%0d: got grant=%b, required %b", f, grant, exp_g);
            end
            if (f > 0) begin
                checks++;
                if (gap != IFG_CYC + 1) begin
                    errors++;
                    $display("FAIL t2_gap%0d: got %0d idle cycles, required %0d", f, gap, IFG_CYC + 1);
                end
            end
            drive_byte(f % 4, 16'd1, 8'h10 + 8'(f), 1'b1);
            drive_byte(f % 4, 16'hFFFF, 8'h00, 1'b0);
        end
        req = '0;
    endtask

    task automatic test_isolation();
        do_reset();
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk);
        #1;
        req = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid[2]     = 1'b1;
            in_byte[32 +: 16] = (k == 5) ? 16'hFFFF : 16'(k);
            in_data[16 +: 8]  = 8'h55;
            if (k % 2 == 0) begin
                in_valid[1]       = 1'b1;
                in_byte[16 +: 16] = 16'(k + 1);
                in_data[8 +: 8]   = 8'hB0 + 8'(k);
                sb.push_back({16'(k + 1), 8'hB0 + 8'(k)});
            end
            @(posedge clk);
            #1;
            in_valid = '0;
            checks++;
            if (grant !== 4'b0010) begin
                errors++;
                $display("FAIL t3_grant%0d: got %b, required 0010", k, grant);
            end
        end
        drive_byte(1, 16'hFFFF, 8'h00, 1'b0);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL t3_end: got grant=%b, required 0000", grant);
        end
        repeat (30) @(posedge clk);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk);
        #1;
        req = '0;
        n = 0;
        while (grant !== 4'b0000 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != TO_CYC) begin
            errors++;
            $display("FAIL t4_timeout: got grant held %0d cycles, required %0d", n, TO_CYC);
        end
        checks++;
        if (abort_cnt !== 16'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t4_abort: got abort=%0d busy=%b, required 1/1", abort_cnt, busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != IFG_CYC) begin
            errors++;
            $display("FAIL t4_ifg: got %0d busy cycles, required %0d", n, IFG_CYC);
        end
    endtask

    task automatic test_link_down();
        bit seen;
        do_reset();
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk);
        #1;
        req = '0;
        drive_byte(0, 16'd1, 8'hC0, 1'b1);
        drive_byte(0, 16'd2, 8'hC1, 1'b1);
        @(negedge clk);
        port_link      = 1'b0;
        in_valid[0]    = 1'b1;
        in_byte[0 +: 16] = 16'd3;
        in_data[0 +: 8]  = 8'hC2;
        @(posedge clk);
        #1;
        in_valid = '0;
        checks++;
        if (tx_valid !== 1'b0 || grant !== 4'b0000 || abort_cnt !== 16'd1) begin
            errors++;
            $display("FAIL t5_abort: got v=%b grant=%b abort=%0d, required 0/0000/1", tx_valid, grant, abort_cnt);
        end
        @(negedge clk);
        req  = 4'b0010;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (grant !== 4'b0000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL t5_linkdown_grant: got grant while link low, required none");
        end
        @(negedge clk);
        port_link = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL t5_relink: got grant=%b, required 0010", grant);
        end
        req = '0;
        drive_byte(1, 16'hFFFF, 8'h00, 1'b0);
    endtask

    task automatic test_bad_end_and_reset();
        int n;
        do_reset();
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk);
        #1;
        req = '0;
        drive_byte(0, 16'd1, 8'hD0, 1'b1);
        drive_byte(0, 16'hFFFE, 8'h00, 1'b0);
        checks++;
        if (bad_cnt !== 16'd1 || abort_cnt !== 16'd0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL t6_bad: got bad=%0d abort=%0d grant=%b, required 1/0/0000", bad_cnt, abort_cnt, grant);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk);
        #1;
        req = '0;
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL t6_grant: got %b, required 0010", grant);
        end
        @(negedge clk);
        in_valid[1]       = 1'b1;
        in_byte[16 +: 16] = 16'd1;
        in_data[8 +: 8]   = 8'hE0;
        sb.push_back({16'd1, 8'hE0});
        @(posedge clk);
        #1;
        in_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, tx_valid, tx_byte, tx_data, busy, bad_cnt, abort_cnt} !== '0) begin
            errors++;
            $display("FAIL t6_async_reset: got grant=%b v=%b byte=%h data=%h busy=%b bad=%0d, required all 0",
                     grant, tx_valid, tx_byte, tx_data, busy, bad_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_no_resume: got grant=%b busy=%b, required 0000/0", grant, busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        in_valid  = '0;
        in_byte   = '0;
        in_data   = '0;
        port_link = 1'b1;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_isolation();
        test_timeout();
        test_link_down();
        test_bad_end_and_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending bytes, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
